// File: rtl/vanilla_exe_bubble_profiler.sv
// EXE-stage bubble classifier for the vanilla core profiler: tags each EXE bubble with a cause, blame PC and slot.
// Optional per-cause saturating counters are built when VANILLA_BUBBLE_PROFILER_COUNTERS_EN is defined.
module vanilla_exe_bubble_profiler #(
  parameter int pc_width_p         = 32,
  parameter int data_width_p       = 32,
  parameter int issue_width_p      = 2,
  parameter int num_dep_classes_p  = 7,
  parameter int num_stall_causes_p = 16,
  parameter int counter_width_p    = 32,
  localparam int num_types_lp  = 4 + num_dep_classes_p + num_stall_causes_p,
  localparam int type_width_lp = (num_types_lp > 1) ? $clog2(num_types_lp) : 1,
  localparam int slot_width_lp = (issue_width_p > 1) ? $clog2(issue_width_p) : 1
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic [data_width_p-1:0]                      if_pc_i,
  input  logic [data_width_p-1:0]                      id_pc_i,
  input  logic [data_width_p-1:0]                      exe_pc_i,
  input  logic                                         stall_all_i,
  input  logic                                         icache_miss_i,
  input  logic                                         icache_miss_in_pipe_i,
  input  logic                                         branch_mispredict_i,
  input  logic                                         jalr_mispredict_i,
  input  logic                                         stall_depend_long_op_i,
  input  logic [issue_width_p*num_dep_classes_p-1:0]   dep_class_i,
  input  logic [num_stall_causes_p-1:0]                stall_cause_i,
  input  logic [type_width_lp-1:0]                     cnt_sel_i,
  input  logic                                         cnt_clear_i,
  output logic [type_width_lp-1:0]                     exe_bubble_type_o,
  output logic [pc_width_p-1:0]                        exe_bubble_pc_o,
  output logic [slot_width_lp-1:0]                     exe_bubble_slot_o,
  output logic [counter_width_p-1:0]                   cnt_o
);

  localparam int D = num_dep_classes_p;

  typedef enum logic [1:0] {ID_NONE, ID_BRANCH, ID_JALR, ID_ICACHE} id_bubble_e;

  localparam logic [type_width_lp-1:0] T_NONE   = type_width_lp'(0);
  localparam logic [type_width_lp-1:0] T_BRANCH = type_width_lp'(1);
  localparam logic [type_width_lp-1:0] T_JALR   = type_width_lp'(2);

  logic [pc_width_p-1:0]    r_miss_pc;
  id_bubble_e               r_id_type, w_id_type;
  logic [pc_width_p-1:0]    r_id_pc, w_id_pc;
  logic [type_width_lp-1:0] r_exe_type, w_exe_type;
  logic [pc_width_p-1:0]    r_exe_pc, w_exe_pc;
  logic [slot_width_lp-1:0] r_exe_slot, w_exe_slot;

  logic [D-1:0]                    w_cls_any;
  logic [D-1:0][slot_width_lp-1:0] w_cls_slot;

  logic [pc_width_p-1:0] w_exe_pc_t, w_id_pc_t, w_if_pc_t;
  assign w_exe_pc_t = exe_pc_i[pc_width_p-1:0];
  assign w_id_pc_t  = id_pc_i[pc_width_p-1:0];
  assign w_if_pc_t  = if_pc_i[pc_width_p-1:0];

  // Miss PC tracks the IF fetch that missed, even while the pipe is frozen.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)            r_miss_pc <= '0;
    else if (icache_miss_i) r_miss_pc <= w_if_pc_t;
  end

  always_comb begin
    w_id_type = ID_NONE;
    w_id_pc   = '0;
    if (branch_mispredict_i) begin
      w_id_type = ID_BRANCH;
      w_id_pc   = w_exe_pc_t;
    end else if (jalr_mispredict_i) begin
      w_id_type = ID_JALR;
      w_id_pc   = w_exe_pc_t;
    end else if (icache_miss_in_pipe_i) begin
      w_id_type = ID_ICACHE;
      w_id_pc   = r_miss_pc;
    end
  end

  // Per class: any slot hit, and the lowest slot that hit.
  always_comb begin
    w_cls_any  = '0;
    w_cls_slot = '0;
    for (int c = 0; c < D; c++) begin
      for (int s = issue_width_p - 1; s >= 0; s--) begin
        if (dep_class_i[s*D + c]) begin
          w_cls_any[c]  = 1'b1;
          w_cls_slot[c] = slot_width_lp'(s);
        end
      end
    end
  end

  always_comb begin
    w_exe_type = T_NONE;
    w_exe_pc   = '0;
    w_exe_slot = '0;
    if (branch_mispredict_i) begin
      w_exe_type = T_BRANCH;
      w_exe_pc   = w_exe_pc_t;
    end else if (jalr_mispredict_i) begin
      w_exe_type = T_JALR;
      w_exe_pc   = w_exe_pc_t;
    end else if (r_id_type != ID_NONE) begin
      w_exe_type = type_width_lp'(r_id_type);
      w_exe_pc   = r_id_pc;
    end else if (stall_depend_long_op_i && |w_cls_any) begin
      w_exe_pc = w_id_pc_t;
      for (int c = D - 1; c >= 0; c--) begin
        if (w_cls_any[c]) begin
          w_exe_type = type_width_lp'(4 + c);
          w_exe_slot = w_cls_slot[c];
        end
      end
    end else if (|stall_cause_i) begin
      w_exe_pc = w_id_pc_t;
      for (int k = num_stall_causes_p - 1; k >= 0; k--) begin
        if (stall_cause_i[k]) w_exe_type = type_width_lp'(4 + D + k);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_id_type  <= ID_NONE;
      r_id_pc    <= '0;
      r_exe_type <= '0;
      r_exe_pc   <= '0;
      r_exe_slot <= '0;
    end else if (!stall_all_i) begin
      r_id_type  <= w_id_type;
      r_id_pc    <= w_id_pc;
      r_exe_type <= w_exe_type;
      r_exe_pc   <= w_exe_pc;
      r_exe_slot <= w_exe_slot;
    end
  end

  assign exe_bubble_type_o = r_exe_type;
  assign exe_bubble_pc_o   = r_exe_pc;
  assign exe_bubble_slot_o = r_exe_slot;

`ifdef VANILLA_BUBBLE_PROFILER_COUNTERS_EN
  logic [counter_width_p-1:0] r_cnt [num_types_lp];

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int t = 0; t < num_types_lp; t++) r_cnt[t] <= '0;
    end else if (cnt_clear_i) begin
      for (int t = 0; t < num_types_lp; t++) r_cnt[t] <= '0;
    end else if (!stall_all_i) begin
      for (int t = 0; t < num_types_lp; t++) begin
        if (w_exe_type == type_width_lp'(t) && r_cnt[t] != '1)
          r_cnt[t] <= r_cnt[t] + counter_width_p'(1);
      end
    end
  end

  always_comb begin
    cnt_o = '0;
    for (int t = 0; t < num_types_lp; t++) begin
      if (cnt_sel_i == type_width_lp'(t)) cnt_o = r_cnt[t];
    end
  end
`else
  logic w_unused_cnt;
  assign w_unused_cnt = ^{cnt_sel_i, cnt_clear_i};
  assign cnt_o = '0;
`endif

  logic w_unused_pc;
  assign w_unused_pc = ^{if_pc_i, id_pc_i, exe_pc_i};

endmodule

// File: tb/tb_vanilla_exe_bubble_profiler.sv
// Directed scoreboard bench for vanilla_exe_bubble_profiler (counter checks follow VANILLA_BUBBLE_PROFILER_COUNTERS_EN).
module tb_vanilla_exe_bubble_profiler;
  localparam int ND = 7, NS = 16, NW = 2, CW = 4;
  localparam int NT = 4 + ND + NS;

  logic              clk = 1'b0, reset_i = 1'b1;
  logic [31:0]       if_pc_i, id_pc_i, exe_pc_i;
  logic              stall_all_i, icache_miss_i, icache_miss_in_pipe_i;
  logic              branch_mispredict_i, jalr_mispredict_i, stall_depend_long_op_i;
  logic [NW*ND-1:0]  dep_class_i;
  logic [NS-1:0]     stall_cause_i;
  logic [4:0]        cnt_sel_i;
  logic              cnt_clear_i;
  logic [4:0]        type_o;
  logic [31:0]       pc_o;
  logic [0:0]        slot_o;
  logic [CW-1:0]     cnt_o;

  vanilla_exe_bubble_profiler #(.counter_width_p(CW)) dut (
    .clk_i(clk), .reset_i(reset_i), .if_pc_i(if_pc_i), .id_pc_i(id_pc_i), .exe_pc_i(exe_pc_i),
    .stall_all_i(stall_all_i), .icache_miss_i(icache_miss_i), .icache_miss_in_pipe_i(icache_miss_in_pipe_i),
    .branch_mispredict_i(branch_mispredict_i), .jalr_mispredict_i(jalr_mispredict_i),
    .stall_depend_long_op_i(stall_depend_long_op_i), .dep_class_i(dep_class_i), .stall_cause_i(stall_cause_i),
    .cnt_sel_i(cnt_sel_i), .cnt_clear_i(cnt_clear_i), .exe_bubble_type_o(type_o),
    .exe_bubble_pc_o(pc_o), .exe_bubble_slot_o(slot_o), .cnt_o(cnt_o));

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] t; logic [31:0] pc; logic s; } exp_t;
  exp_t q[$];
  int unsigned exp_cnt [NT];
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [4:0] sel);
    logic [31:0] want;
    cnt_sel_i = sel;
    #1;
`ifdef VANILLA_BUBBLE_PROFILER_COUNTERS_EN
    want = (int'(sel) < NT) ? exp_cnt[sel] : 0;
`else
    want = 0;
`endif
    chk(tag, {28'd0, cnt_o}, want);
  endtask

  task automatic idle();
    stall_all_i = 0; icache_miss_i = 0; icache_miss_in_pipe_i = 0;
    branch_mispredict_i = 0; jalr_mispredict_i = 0; stall_depend_long_op_i = 0;
    dep_class_i = '0; stall_cause_i = '0; cnt_clear_i = 0;
  endtask

  task automatic model_clear();
    for (int t = 0; t < NT; t++) exp_cnt[t] = 0;
  endtask

  // Push the expected EXE outcome for the inputs now applied, clock once, then pop and compare.
  task automatic step(input string tag, input logic [4:0] t, input logic [31:0] pc, input logic s);
    exp_t e;
    e.t = t; e.pc = pc; e.s = s;
    q.push_back(e);
    if (cnt_clear_i) model_clear();
    else if (!stall_all_i && exp_cnt[t] != (1 << CW) - 1) exp_cnt[t]++;
    @(posedge clk); #1;
    e = q.pop_front();
    chk({tag, ".type"}, {27'd0, type_o}, {27'd0, e.t});
    chk({tag, ".pc"}, pc_o, e.pc);
    chk({tag, ".slot"}, {31'd0, slot_o}, {31'd0, e.s});
  endtask

  initial begin
    idle();
    if_pc_i = 0; id_pc_i = 0; exe_pc_i = 0; cnt_sel_i = 0;
    model_clear();
    #2;
    chk("rst.type", {27'd0, type_o}, 0);
    chk("rst.pc", pc_o, 0);
    chk("rst.slot", {31'd0, slot_o}, 0);
    chk_cnt("rst.cnt", 5'd0);
    @(posedge clk); #1;
    reset_i = 0;

    // Branch vs. icache/jalr priority
    branch_mispredict_i = 1; exe_pc_i = 32'h1000;
    step("br", 5'd1, 32'h1000, 0);
    idle(); jalr_mispredict_i = 1; icache_miss_in_pipe_i = 1; exe_pc_i = 32'h1100;
    step("jalr_live", 5'd2, 32'h1100, 0);
    idle(); exe_pc_i = 32'h1200;
    step("jalr_from_id", 5'd2, 32'h1100, 0);
    step("none", 5'd0, 32'h0, 0);

    // Icache blame PC
    icache_miss_i = 1; if_pc_i = 32'h2040;
    step("ic_miss", 5'd0, 32'h0, 0);
    idle(); if_pc_i = 32'h3000;
    step("ic_wait", 5'd0, 32'h0, 0);
    icache_miss_in_pipe_i = 1;
    step("ic_inpipe", 5'd0, 32'h0, 0);
    idle();
    step("ic_exe", 5'd3, 32'h2040, 0);

    // Dependency classes and slots
    stall_depend_long_op_i = 1; id_pc_i = 32'h4444; dep_class_i = 14'h04A0; stall_cause_i = 16'h0001;
    step("dep_slot1", 5'd4, 32'h4444, 1);
    dep_class_i = 14'h0204; id_pc_i = 32'h4448;
    step("dep_slot0", 5'd6, 32'h4448, 0);
    dep_class_i = 14'h0100; stall_cause_i = '0;
    step("dep_c1s1", 5'd5, 32'h4448, 1);
    stall_depend_long_op_i = 0; dep_class_i = 14'h3FFF; stall_cause_i = 16'h0220; id_pc_i = 32'h5000;
    step("dep_ignored", 5'd16, 32'h5000, 0);
    stall_depend_long_op_i = 1; dep_class_i = '0; stall_cause_i = 16'h8001;
    step("dep_empty", 5'd11, 32'h5000, 0);
    stall_depend_long_op_i = 0; stall_cause_i = 16'h8000;
    step("cause15", 5'd26, 32'h5000, 0);
    stall_depend_long_op_i = 1; dep_class_i = 14'h0001; branch_mispredict_i = 1; exe_pc_i = 32'h5100;
    step("br_over_dep", 5'd1, 32'h5100, 0);
    idle(); step("flush_id", 5'd1, 32'h5100, 0);
    stall_cause_i = 16'h0010; id_pc_i = 32'h6000;
    step("cause4", 5'd15, 32'h6000, 0);

    // Freeze: outputs and counters hold; miss PC still loads
    chk_cnt("pre_freeze.cnt15", 5'd15);
    stall_all_i = 1;
    for (int i = 0; i < 5; i++) begin
      branch_mispredict_i = (i % 2 == 0); exe_pc_i = 32'h9990 + i;
      stall_cause_i = 16'h0001 << i; icache_miss_i = (i == 3); if_pc_i = 32'h5550 + (i == 3 ? 0 : 4);
      step("freeze", 5'd15, 32'h6000, 0);
    end
    chk_cnt("freeze.cnt15", 5'd15);
    chk_cnt("freeze.cnt1", 5'd1);
    idle(); icache_miss_in_pipe_i = 1;
    step("thaw", 5'd0, 32'h0, 0);
    idle();
    step("thaw_ic", 5'd3, 32'h5550, 0);

    // Counter saturation, clear priority, out-of-range select
    stall_cause_i = 16'h0004; id_pc_i = 32'h7000;
    for (int i = 0; i < 20; i++) step("sat", 5'd13, 32'h7000, 0);
    chk_cnt("sat.cnt13", 5'd13);
    chk_cnt("cnt0", 5'd0);
    chk_cnt("cnt3", 5'd3);
    chk_cnt("sel_oor", 5'd31);
    cnt_clear_i = 1;
    step("clr", 5'd13, 32'h7000, 0);
    cnt_clear_i = 0;
    chk_cnt("clr.cnt13", 5'd13);
    chk_cnt("clr.cnt0", 5'd0);
    step("post_clr", 5'd13, 32'h7000, 0);
    step("post_clr2", 5'd13, 32'h7000, 0);
    chk_cnt("post_clr.cnt13", 5'd13);

    // Asynchronous reset mid-run takes effect before the next edge
    cnt_sel_i = 5'd13;
    reset_i = 1;
    #1;
    model_clear();
    chk("arst.type", {27'd0, type_o}, 0);
    chk("arst.pc", pc_o, 0);
    chk("arst.slot", {31'd0, slot_o}, 0);
    chk("arst.cnt", {28'd0, cnt_o}, 0);
    #1; reset_i = 0;
    idle();
    step("after_rst", 5'd0, 32'h0, 0);
    chk_cnt("after_rst.cnt0", 5'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
